// File: rtl/fsm_seq_rx.sv
// ============================================================================
// Module   : fsm_seq_rx
// Purpose  : Serial frame receiver. It hunts a 1-0-1 preamble, shifts in a
//            payload MSB first, checks the stop bit and reports good frames.
// Options  : FSM_SEQ_RX_PARITY_EN adds an even-parity bit after the payload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_seq_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              s_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy
);

    localparam int                    c_BCNT_W   = $clog2(DATA_W + 1);
    localparam logic [c_BCNT_W-1:0]   c_LAST_BIT = c_BCNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE1 = 3'd1,
        S_PRE2 = 3'd2,
        S_DATA = 3'd3,
        S_PAR  = 3'd4,
        S_STOP = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_BCNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_err;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_good;

    // New bits enter at the LSB so the first payload bit ends up as the MSB.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign w_shift_next = s_in;
        end else begin : g_shift_wide
            assign w_shift_next = {r_shift[DATA_W-2:0], s_in};
        end
    endgenerate

`ifdef FSM_SEQ_RX_PARITY_EN
    logic r_par_err;
    // A parity mismatch rejects the frame regardless of the stop bit value.
    assign w_good = !s_in && !r_par_err;
`else
    assign w_good = !s_in;
`endif

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
`ifdef FSM_SEQ_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_in) r_state <= S_PRE1;
                end
                S_PRE1: begin
                    if (!s_in) r_state <= S_PRE2;
                end
                S_PRE2: begin
                    if (s_in) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + c_BCNT_W'(1);
                    if (r_cnt == c_LAST_BIT) begin
`ifdef FSM_SEQ_RX_PARITY_EN
                        r_state <= S_PAR;
`else
                        r_state <= S_STOP;
`endif
                    end
                end
                S_PAR: begin
`ifdef FSM_SEQ_RX_PARITY_EN
                    r_par_err <= ^{r_shift, s_in};
                    r_state   <= S_STOP;
`else
                    r_state   <= S_IDLE;
`endif
                end
                S_STOP: begin
                    if (w_good) begin
                        r_data      <= r_shift;
                        r_valid     <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end else begin
                        r_err       <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_err;
    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fsm_seq_rx.sv
// ============================================================================
// Module   : tb_fsm_seq_rx
// Purpose  : Self-checking bench for fsm_seq_rx, using frame-level stimulus
//            and per-bit expectations built from the frame format.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_seq_rx;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
`ifdef FSM_SEQ_RX_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              R   = 1'b1;
    logic              s_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Per-bit stimulus and the outputs expected right after that bit's edge.
    bit               q_s[$];
    bit               q_v[$];
    bit               q_e[$];
    bit               q_b[$];
    logic [DATA_W-1:0] q_d[$];
    logic [CNT_W-1:0]  q_c[$];

    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;

    fsm_seq_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .CLK       (CLK),
        .R         (R),
        .s_in      (s_in),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic clear_q();
        q_s.delete(); q_v.delete(); q_e.delete();
        q_b.delete(); q_d.delete(); q_c.delete();
    endtask

    task automatic push(input bit b, input bit bz, input bit v, input bit e);
        q_s.push_back(b);
        q_b.push_back(bz);
        q_v.push_back(v);
        q_e.push_back(e);
        q_d.push_back(m_data);
        q_c.push_back(m_cnt);
    endtask

    task automatic add_gap(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Leading 1s before a preamble keep the receiver waiting for the 0.
    task automatic add_ones(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic add_junk100();
        push(1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_frame(input logic [DATA_W-1:0] p, input bit stop, input bit flip_par);
        bit par_ok;
        bit good;
        par_ok = 1'b1;
        push(1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) push(p[i], 1'b1, 1'b0, 1'b0);
        if (c_PAR) begin
            push((^p) ^ flip_par, 1'b1, 1'b0, 1'b0);
            par_ok = !flip_par;
        end
        good = !stop && par_ok;
        if (good) begin
            m_data = p;
            m_cnt  = m_cnt + 1'b1;
        end
        push(stop, 1'b0, good, !good);
    endtask

    task automatic drive(input bit b);
        @(negedge CLK);
        s_in = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        R    = 1'b1;
        s_in = 1'($urandom);
        @(posedge CLK);
        #1;
        R = 1'b0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        R    = 1'b1;
        s_in = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({valid, frame_err, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes: got v=%b e=%b busy=%b want 0 0 0", valid, frame_err, busy);
        end
        total++;
        if (data_out !== '0 || frame_cnt !== '0) begin
            bad++;
            $display("FAIL reset_regs: got data=%h cnt=%0d want 00 0", data_out, frame_cnt);
        end
        R = 1'b0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    task automatic test_good_frame();
        clear_q();
        add_frame(8'hA5, 1'b0, 1'b0);
        add_gap(2);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL good_frame bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
    endtask

    task automatic test_bad_stop();
        clear_q();
        add_frame(8'hA5, 1'b1, 1'b0);
        add_gap(1);
        add_frame(8'h5A, 1'b1, 1'b0);
        add_gap(1);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL bad_stop bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
    endtask

    task automatic test_preamble_hunt();
        clear_q();
        add_ones(2);
        add_frame(8'h3C, 1'b0, 1'b0);
        add_junk100();
        add_frame(8'hC3, 1'b0, 1'b0);
        add_gap(1);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL preamble_hunt bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        add_frame(8'h96, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]}) begin
                bad++;
                $display("FAIL mid_reset_pre bit %0d: got v=%b e=%b b=%b want v=%b e=%b b=%b",
                         i, valid, frame_err, busy, q_v[i], q_e[i], q_b[i]);
            end
        end
        do_reset();
        total++;
        if ({valid, frame_err, busy} !== 3'b000 || data_out !== '0 || frame_cnt !== '0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b e=%b b=%b d=%h c=%0d want all 0",
                     valid, frame_err, busy, data_out, frame_cnt);
        end
        clear_q();
        add_frame(8'h71, 1'b0, 1'b0);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL mid_reset_after bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_valid;
        n_valid = 0;
        do_reset();
        clear_q();
        for (int f = 0; f < 17; f++) add_frame(8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            if (valid === 1'b1) n_valid++;
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL back_to_back bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
        total++;
        if (n_valid != 17 || frame_cnt !== 4'd1) begin
            bad++;
            $display("FAIL back_to_back_count: got strobes=%0d cnt=%0d want 17 1", n_valid, frame_cnt);
        end
    endtask

`ifdef FSM_SEQ_RX_PARITY_EN
    task automatic test_parity();
        clear_q();
        add_frame(8'hA5, 1'b0, 1'b0);
        add_frame(8'hA5, 1'b0, 1'b1);
        add_frame(8'h01, 1'b0, 1'b0);
        add_gap(1);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL parity bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        clear_q();
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0: add_gap($urandom_range(1, 3));
                1: add_ones($urandom_range(1, 3));
                2: add_junk100();
                default: ;
            endcase
            add_frame(8'($urandom), ($urandom_range(0, 3) == 0),
                      c_PAR && ($urandom_range(0, 3) == 0));
        end
        add_gap(1);
        for (int i = 0; i < q_s.size(); i++) begin
            drive(q_s[i]);
            total++;
            if ({valid, frame_err, busy} !== {q_v[i], q_e[i], q_b[i]} ||
                data_out !== q_d[i] || frame_cnt !== q_c[i]) begin
                bad++;
                $display("FAIL random bit %0d: got v=%b e=%b b=%b d=%h c=%0d want v=%b e=%b b=%b d=%h c=%0d",
                         i, valid, frame_err, busy, data_out, frame_cnt,
                         q_v[i], q_e[i], q_b[i], q_d[i], q_c[i]);
            end
            total++;
            if (valid === 1'b1 && frame_err === 1'b1) begin
                bad++;
                $display("FAIL random_exclusive bit %0d: got v=1 e=1 want not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
        test_preamble_hunt();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef FSM_SEQ_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
